// File: rtl/cdc_req_arbiter.sv
// Round-robin arbiter sharing one 4-phase req/ack CDC link among NUM_REQ clk_a-domain producers.
// Optional handshake watchdog enabled by defining CDC_ARB_TIMEOUT_EN.
module cdc_req_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DW          = 4,
  parameter int SETUP_CYC   = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                       clk_a,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DW-1:0]      req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [DW-1:0]              data,
  output logic                       data_req,
  input  logic                       data_ack,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       err
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int SCW = $clog2(SETUP_CYC + 1);

  if (NUM_REQ < 2 || NUM_REQ > 8 || SETUP_CYC < 1 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("cdc_req_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, SETUP, REQ, RELEASE} state_t;

  state_t          state, state_nxt;
  logic            ack_meta, ack_s;
  logic [IDW-1:0]  ptr, gnt_idx, cand;
  logic            gnt_any;
  logic [SCW-1:0]  setup_cnt;
  logic            do_grant, do_req_set, do_req_clr, do_err;
  logic            wd_hit;
  logic [DW-1:0]   words [NUM_REQ];

  // data_ack is asynchronous to clk_a; only the synchronized copy is used
  always_ff @(posedge clk_a or posedge rst) begin
    if (rst) begin
      ack_meta <= 1'b0;
      ack_s    <= 1'b0;
    end else begin
      ack_meta <= data_ack;
      ack_s    <= ack_meta;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      words[i] = req_data[i*DW +: DW];
    end
  end

  // Descending scan so the lowest offset from ptr+1 wins
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IDW'((int'(ptr) + k) % NUM_REQ);
      if (req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

`ifdef CDC_ARB_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYC + 1);
  logic [WDW-1:0] wd_cnt;

  assign wd_hit = (wd_cnt == WDW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk_a or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
    end else if (state == SETUP && state_nxt == REQ) begin
      wd_cnt <= '0;
    end else if (state == REQ || state == RELEASE) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  assign wd_hit = 1'b0;
`endif

  always_ff @(posedge clk_a or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    do_grant   = 1'b0;
    do_req_set = 1'b0;
    do_req_clr = 1'b0;
    do_err     = 1'b0;
    case (state)
      IDLE: begin
        // A stale ack from an earlier (possibly aborted) handshake blocks new grants
        if (gnt_any && !ack_s) begin
          do_grant  = 1'b1;
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        if (setup_cnt == SCW'(SETUP_CYC)) begin
          do_req_set = 1'b1;
          state_nxt  = REQ;
        end
      end
      REQ: begin
        if (wd_hit) begin
          do_req_clr = 1'b1;
          do_err     = 1'b1;
          state_nxt  = IDLE;
        end else if (ack_s) begin
          do_req_clr = 1'b1;
          state_nxt  = RELEASE;
        end
      end
      RELEASE: begin
        if (wd_hit) begin
          do_err    = 1'b1;
          state_nxt = IDLE;
        end else if (!ack_s) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_a or posedge rst) begin
    if (rst) begin
      setup_cnt <= '0;
    end else if (do_grant) begin
      setup_cnt <= '0;
    end else if (state == SETUP && !do_req_set) begin
      setup_cnt <= setup_cnt + 1'b1;
    end
  end

  // Link outputs; data only changes on a grant so it stays stable through the handshake
  always_ff @(posedge clk_a or posedge rst) begin
    if (rst) begin
      data      <= '0;
      data_req  <= 1'b0;
      req_ready <= '0;
      grant_id  <= '0;
      err       <= 1'b0;
      ptr       <= IDW'(NUM_REQ - 1);
    end else begin
      req_ready <= '0;
      err       <= do_err;
      if (do_grant) begin
        data               <= words[gnt_idx];
        grant_id           <= gnt_idx;
        ptr                <= gnt_idx;
        req_ready[gnt_idx] <= 1'b1;
      end
      if (do_req_set) begin
        data_req <= 1'b1;
      end else if (do_req_clr) begin
        data_req <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule
